// File: rtl/hub75_fb_arbiter.sv
// Framebuffer RAM port arbiter: panel readout has priority, host writes are
// buffered in a small FIFO and drained in idle read cycles. A starvation
// counter forces one write slot after max_starve_p consecutive read grants
// while writes are pending.
module hub75_fb_arbiter #(
  parameter int unsigned addr_width_p = 11,
  parameter int unsigned data_width_p = 48,
  parameter int unsigned fifo_depth_p = 4,
  parameter int unsigned max_starve_p = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_wr_valid,
  output logic                    o_wr_ready,
  input  logic [addr_width_p-1:0] i_wr_addr,
  input  logic [data_width_p-1:0] i_wr_data,
  input  logic                    i_rd_req,
  input  logic [addr_width_p-1:0] i_rd_addr,
  output logic                    o_rd_gnt,
  output logic                    o_rd_valid,
  output logic [data_width_p-1:0] o_rd_data,
  output logic                    o_mem_en,
  output logic                    o_mem_we,
  output logic [addr_width_p-1:0] o_mem_addr,
  output logic [data_width_p-1:0] o_mem_wdata,
  input  logic [data_width_p-1:0] i_mem_rdata
);

  localparam int unsigned ptr_width_lp    = $clog2(fifo_depth_p);
  localparam int unsigned cnt_width_lp    = $clog2(fifo_depth_p) + 1;
  localparam int unsigned starve_width_lp = $clog2(max_starve_p + 1);

  logic [addr_width_p-1:0]    fifo_addr_q [fifo_depth_p];
  logic [data_width_p-1:0]    fifo_data_q [fifo_depth_p];
  logic [ptr_width_lp-1:0]    wr_ptr_q, wr_ptr_d;
  logic [ptr_width_lp-1:0]    rd_ptr_q, rd_ptr_d;
  logic [cnt_width_lp-1:0]    count_q, count_d;
  logic [starve_width_lp-1:0] starve_cnt_q, starve_cnt_d;
  logic                       rd_valid_q;

  logic fifo_empty;
  logic starve;
  logic rd_gnt;
  logic wr_gnt;
  logic push;

  // Grant decision and RAM port mux; reset low masks every grant.
  always_comb begin
    fifo_empty  = (count_q == '0);
    starve      = !fifo_empty && (starve_cnt_q == starve_width_lp'(max_starve_p));
    rd_gnt      = rst_n && i_rd_req && !starve;
    wr_gnt      = rst_n && !fifo_empty && (!i_rd_req || starve);
    o_wr_ready  = (count_q != cnt_width_lp'(fifo_depth_p));
    push        = i_wr_valid && o_wr_ready;
    o_rd_gnt    = rd_gnt;
    o_mem_en    = rd_gnt || wr_gnt;
    o_mem_we    = wr_gnt;
    o_mem_addr  = rd_gnt ? i_rd_addr : fifo_addr_q[rd_ptr_q];
    o_mem_wdata = fifo_data_q[rd_ptr_q];
    o_rd_valid  = rd_valid_q;
    o_rd_data   = i_mem_rdata;
  end

  // Next-state for FIFO pointers, occupancy and starvation counter.
  always_comb begin
    wr_ptr_d     = push ? wr_ptr_q + ptr_width_lp'(1) : wr_ptr_q;
    rd_ptr_d     = wr_gnt ? rd_ptr_q + ptr_width_lp'(1) : rd_ptr_q;
    count_d      = count_q;
    starve_cnt_d = starve_cnt_q;
    unique case ({push, wr_gnt})
      2'b10:   count_d = count_q + cnt_width_lp'(1);
      2'b01:   count_d = count_q - cnt_width_lp'(1);
      default: count_d = count_q;
    endcase
    if (fifo_empty || wr_gnt) begin
      starve_cnt_d = '0;
    end else if (rd_gnt && (starve_cnt_q != starve_width_lp'(max_starve_p))) begin
      starve_cnt_d = starve_cnt_q + starve_width_lp'(1);
    end
  end

  // Control state; async reset discards queued writes and in-flight reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      starve_cnt_q <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      starve_cnt_q <= starve_cnt_d;
      rd_valid_q   <= rd_gnt;
    end
  end

  // FIFO storage; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= i_wr_addr;
      fifo_data_q[wr_ptr_q] <= i_wr_data;
    end
  end

endmodule
